pipe_expr_hs: RTL

Parametrised three-stage arithmetic pipeline that computes F = ((A+B) ± (C−D))·D on N-bit operands. It adds a valid/ready handshake on both sides, full backpressure, a synchronous reset and a per-transaction mode select. It sits in the datapath as a streaming arithmetic stage and sustains one result per cycle when the output is not stalled.

---
 rtl/pipe_expr_hs_if.sv | 27 ++
 rtl/pipe_expr_hs.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/pipe_expr_hs_if.sv
// Stream handshake bundle for pipe_expr_hs: operand side (in_*) and result side (out_*).
// The slave modport is the pipeline's view; the master modport is the source/sink view.
interface pipe_expr_hs_if #(
  parameter int N = 10
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] C;
  logic [N-1:0] D;
  logic         mode;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] F;
  logic         out_ovf;

  modport slave (
    input  in_valid, A, B, C, D, mode, out_ready,
    output in_ready, out_valid, F, out_ovf
  );

  modport master (
    output in_valid, A, B, C, D, mode, out_ready,
    input  in_ready, out_valid, F, out_ovf
  );
endinterface

// File: rtl/pipe_expr_hs.sv
// Three-stage streaming pipeline F = ((A+B) +/- (C-D)) * D with valid/ready backpressure.
// Define PIPE_EXPR_SAT_EN to clamp F to [0, 2^N-1] and flag clamping on out_ovf; otherwise F wraps.
module pipe_expr_hs #(
  parameter int N = 10
) (
  input  logic           clk,
  input  logic           rst,
  pipe_expr_hs_if.slave  bus
);
  localparam int W1 = N + 1;
  localparam int W3 = N + 3;
  localparam int PW = 2 * N + 3;

`ifdef PIPE_EXPR_SAT_EN
  localparam logic signed [PW-1:0] F_MAX = {{(PW-N){1'b0}}, {N{1'b1}}};

  function automatic logic [N:0] sat_res(input logic signed [PW-1:0] p);
    logic [N:0] r;
    r = {1'b0, N'(p)};
    if (p[PW-1])
      r = {1'b1, {N{1'b0}}};
    else if (p > F_MAX)
      r = {1'b1, {N{1'b1}}};
    return r;
  endfunction
`else
  function automatic logic [N-1:0] wrap_res(input logic signed [PW-1:0] p);
    return N'(p);
  endfunction
`endif

  logic adv1, adv2, adv3, in_rdy;

  logic                 vld_p1_q, vld_p1_d;
  logic        [W1-1:0] x1_p1_q, x1_p1_d;
  logic signed [W1-1:0] x2_p1_q, x2_p1_d;
  logic        [N-1:0]  d_p1_q, d_p1_d;
  logic                 mode_p1_q, mode_p1_d;

  logic                 vld_p2_q, vld_p2_d;
  logic signed [W3-1:0] x3_p2_q, x3_p2_d;
  logic        [N-1:0]  d_p2_q, d_p2_d;
  logic signed [W3-1:0] x1_ext, x2_ext;

  logic                 vld_p3_q, vld_p3_d;
  logic        [N-1:0]  f_p3_q, f_p3_d;
  logic signed [PW-1:0] x3_ext, d_ext, prod;
`ifdef PIPE_EXPR_SAT_EN
  logic                 ovf_p3_q, ovf_p3_d;
`endif

  // Ready chain: a slot may load when it is empty or its occupant moves on this cycle.
  always_comb begin
    adv3   = !vld_p3_q || bus.out_ready;
    adv2   = !vld_p2_q || adv3;
    adv1   = !vld_p1_q || adv2;
    in_rdy = adv1 && !rst;
  end

  assign bus.in_ready = in_rdy;

  // Stage 1: operand sums
  always_comb begin
    vld_p1_d  = vld_p1_q;
    x1_p1_d   = x1_p1_q;
    x2_p1_d   = x2_p1_q;
    d_p1_d    = d_p1_q;
    mode_p1_d = mode_p1_q;
    if (adv1) begin
      vld_p1_d  = bus.in_valid && in_rdy;
      x1_p1_d   = {1'b0, bus.A} + {1'b0, bus.B};
      x2_p1_d   = signed'({1'b0, bus.C} - {1'b0, bus.D});
      d_p1_d    = bus.D;
      mode_p1_d = bus.mode;
    end
  end

  // Stage 2: mode-selected combine, exact in N+3 signed bits
  always_comb begin
    x1_ext   = signed'({2'b00, x1_p1_q});
    x2_ext   = {{2{x2_p1_q[W1-1]}}, x2_p1_q};
    vld_p2_d = vld_p2_q;
    x3_p2_d  = x3_p2_q;
    d_p2_d   = d_p2_q;
    if (adv2) begin
      vld_p2_d = vld_p1_q;
      x3_p2_d  = mode_p1_q ? (x1_ext - x2_ext) : (x1_ext + x2_ext);
      d_p2_d   = d_p1_q;
    end
  end

  // Stage 3: exact product, then wrap or clamp to N bits
  always_comb begin
    x3_ext   = {{N{x3_p2_q[W3-1]}}, x3_p2_q};
    d_ext    = {{(N+3){1'b0}}, d_p2_q};
    prod     = x3_ext * d_ext;
    vld_p3_d = vld_p3_q;
    f_p3_d   = f_p3_q;
`ifdef PIPE_EXPR_SAT_EN
    ovf_p3_d = ovf_p3_q;
    if (adv3) begin
      vld_p3_d           = vld_p2_q;
      {ovf_p3_d, f_p3_d} = sat_res(prod);
    end
`else
    if (adv3) begin
      vld_p3_d = vld_p2_q;
      f_p3_d   = wrap_res(prod);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      x1_p1_q   <= '0;
      x2_p1_q   <= '0;
      d_p1_q    <= '0;
      mode_p1_q <= 1'b0;
      vld_p2_q  <= 1'b0;
      x3_p2_q   <= '0;
      d_p2_q    <= '0;
      vld_p3_q  <= 1'b0;
      f_p3_q    <= '0;
`ifdef PIPE_EXPR_SAT_EN
      ovf_p3_q  <= 1'b0;
`endif
    end else begin
      vld_p1_q  <= vld_p1_d;
      x1_p1_q   <= x1_p1_d;
      x2_p1_q   <= x2_p1_d;
      d_p1_q    <= d_p1_d;
      mode_p1_q <= mode_p1_d;
      vld_p2_q  <= vld_p2_d;
      x3_p2_q   <= x3_p2_d;
      d_p2_q    <= d_p2_d;
      vld_p3_q  <= vld_p3_d;
      f_p3_q    <= f_p3_d;
`ifdef PIPE_EXPR_SAT_EN
      ovf_p3_q  <= ovf_p3_d;
`endif
    end
  end

  assign bus.out_valid = vld_p3_q;
  assign bus.F         = f_p3_q;
`ifdef PIPE_EXPR_SAT_EN
  assign bus.out_ovf   = ovf_p3_q;
`else
  assign bus.out_ovf   = 1'b0;
`endif

endmodule
